// File: rtl/reversible_adder_garbage_reclaimer.sv
// reversible_adder_garbage_reclaimer
// Sits behind an 8-bit Peres-gate ripple adder. It takes the sum, the carry-out
// and the garbage lines, and walks the stages LSB first. For each stage it
// recovers operand b, recomputes the carry and restores the ancilla. The cleaned
// result, with ancilla and carry error flags, is presented on a valid/ready port.
// Optional feature: define RECLAIM_ERRCNT_EN to build the saturating 8-bit
// count of bad results on err_count. Without it, err_count is tied to zero.
module reversible_adder_garbage_reclaimer #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_g_a,
  input  logic [WIDTH-1:0] in_g_ab,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_anc_ok,
  output logic [WIDTH-1:0] out_bad_mask,
  output logic             out_carry_err,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  // Undo one Peres stage. The function returns {b, restored ancilla, carry out}.
  // If the ancilla was restored correctly it reads back as 0.
  function automatic logic [2:0] peres_uncompute(input logic sum_bit,
                                                 input logic a_bit,
                                                 input logic g_ab_bit,
                                                 input logic c_bit);
    logic b_bit;
    logic anc_bit;
    logic c_next;
    b_bit   = sum_bit ^ a_bit ^ c_bit;
    anc_bit = g_ab_bit ^ (a_bit & b_bit);
    c_next  = ((a_bit ^ b_bit) & c_bit) ^ (a_bit & b_bit);
    return {b_bit, anc_bit, c_next};
  endfunction

  state_t           state_r;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic             in_ready_r;
  logic             valid_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic [WIDTH-1:0] g_ab_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] mask_r;
  logic             anc_ok_r;
  logic             carry_err_r;

  logic [2:0]       stage_s;
  logic [WIDTH-1:0] b_next_s;
  logic [WIDTH-1:0] mask_next_s;
  logic             last_bit_s;

  // Evaluate the stage at idx and form the b/mask words with that bit merged in.
  always_comb begin
    stage_s              = peres_uncompute(sum_r[idx_r], a_r[idx_r], g_ab_r[idx_r], carry_r);
    b_next_s             = b_r;
    b_next_s[idx_r]      = stage_s[2];
    mask_next_s          = mask_r;
    mask_next_s[idx_r]   = stage_s[1];
    last_bit_s           = (idx_r == IDX_W'(WIDTH - 1));
  end

  // Control FSM plus all result registers. Reset drops any in-flight item.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      carry_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      valid_r     <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      g_ab_r      <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      mask_r      <= {WIDTH{1'b0}};
      anc_ok_r    <= 1'b0;
      carry_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r         <= in_g_a;
            sum_r       <= in_sum;
            cout_r      <= in_cout;
            g_ab_r      <= in_g_ab;
            carry_r     <= in_cin;
            idx_r       <= {IDX_W{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            mask_r      <= {WIDTH{1'b0}};
            anc_ok_r    <= 1'b0;
            carry_err_r <= 1'b0;
            in_ready_r  <= 1'b0;
            state_r     <= WALK;
          end else begin
            in_ready_r  <= 1'b1;
          end
        end
        WALK: begin
          b_r     <= b_next_s;
          mask_r  <= mask_next_s;
          carry_r <= stage_s[0];
          if (last_bit_s) begin
            carry_err_r <= (stage_s[0] != cout_r);
            anc_ok_r    <= ~|mask_next_s;
            valid_r     <= 1'b1;
            state_r     <= DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_r    <= 1'b0;
            in_ready_r <= 1'b1;
            state_r    <= IDLE;
          end else begin
            valid_r    <= 1'b1;
          end
        end
        default: begin
          valid_r    <= 1'b0;
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end

`ifdef RECLAIM_ERRCNT_EN
  logic [7:0] err_count_r;

  // Count delivered results that carry an ancilla or carry fault. The count saturates at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_r <= 8'd0;
    end else if (valid_r && out_ready && (~anc_ok_r | carry_err_r) && (err_count_r != 8'hFF)) begin
      err_count_r <= err_count_r + 8'd1;
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign err_count = err_count_r;
`else
  assign err_count = 8'd0;
`endif

  assign in_ready      = in_ready_r;
  assign out_valid     = valid_r;
  assign out_a         = a_r;
  assign out_b         = b_r;
  assign out_sum       = sum_r;
  assign out_cout      = cout_r;
  assign out_anc_ok    = anc_ok_r;
  assign out_bad_mask  = mask_r;
  assign out_carry_err = carry_err_r;

endmodule
